memory_stage_hs: RTL and testbench

//  Pipeline memory stage (EX/MEM -> MEM/WB) for the 5-stage core, with a valid/ready data-memory port.

---
 rtl/definitions_pkg.sv | 38 +++
 rtl/memory_stage_hs_align.sv | 56 +++++
 rtl/memory_stage_hs.sv | 168 ++++++++++++++++
 tb/tb_memory_stage_hs.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared core definitions: register names, data-memory access sizes and memory-stage states.
package definitions_pkg;

    localparam int CORE_XLEN = 32;

    typedef logic [CORE_XLEN-1:0] word_st;

    typedef enum logic [4:0] {
        REG_ZERO, REG_RA, REG_SP, REG_GP, REG_TP, REG_T0, REG_T1, REG_T2,
        REG_S0, REG_S1, REG_A0, REG_A1, REG_A2, REG_A3, REG_A4, REG_A5,
        REG_A6, REG_A7, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
        REG_S8, REG_S9, REG_S10, REG_S11, REG_T3, REG_T4, REG_T5, REG_T6
    } reg_e;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT,
        MS_DRAIN
    } mem_state_e;

    // Byte-lane mask for an access size; callers keep the low NBYTES bits.
    function automatic logic [7:0] size_mask(input mem_size_e size);
        case (size)
            MEM_B:   size_mask = 8'h01;
            MEM_H:   size_mask = 8'h03;
            MEM_W:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_hs_align.sv
// Combinational byte-lane steering: store enables/data towards memory and
// load extraction with sign/zero extension back into the pipeline.
module mem_lane_align
    import definitions_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int NBYTES = XLEN / 8,
    localparam int OFF_W  = $clog2(NBYTES)
) (
    input  mem_size_e         size,
    input  logic              sign_ext,
    input  logic [OFF_W-1:0]  off,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_data,
    output logic [NBYTES-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_ext
);

    logic [7:0]        mask_full;
    logic [NBYTES-1:0] mask;
    logic [XLEN-1:0]   repl;
    logic [XLEN-1:0]   shifted;
    logic [OFF_W+2:0]  shamt;
    logic              msb;

    always_comb begin
        mask_full = size_mask(size);
        mask      = mask_full[NBYTES-1:0];
        shamt     = {off, 3'b000};
        be        = mask << off;

        case (size)
            MEM_B:   repl = {NBYTES{store_data[7:0]}};
            MEM_H:   repl = {(NBYTES/2){store_data[15:0]}};
            MEM_W:   repl = {(NBYTES/4){store_data[31:0]}};
            default: repl = store_data;
        endcase
        wdata = repl << shamt;

        shifted = load_data >> shamt;
        case (size)
            MEM_B:   msb = shifted[7];
            MEM_H:   msb = shifted[15];
            MEM_W:   msb = shifted[31];
            default: msb = shifted[XLEN-1];
        endcase

        // Lanes outside the access size are filled with the extension bit.
        load_ext = '0;
        for (int i = 0; i < NBYTES; i++) begin
            load_ext[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : {8{sign_ext & msb}};
        end
    end

endmodule

// File: rtl/memory_stage_hs.sv
// Pipeline memory stage with a valid/ready data-memory port and the MEM/WB register.
// MEMORY_STAGE_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged on misalign_mw_o.
module memory_stage_hs
    import definitions_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int ADDR_W = 32,
    localparam int NBYTES = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_mr_i,
    input  logic              mem_read_mr_i,
    input  logic              mem_write_mr_i,
    input  logic              data_memory_sign_mr_i,
    input  logic [1:0]        data_memory_size_mr_i,
    input  logic [XLEN-1:0]   rs2_d_mr_i,
    input  logic [XLEN-1:0]   alu_result_mr_i,
    input  logic [XLEN-1:0]   pc_next_4_mr_i,
    input  logic [XLEN-1:0]   pc_next_imm_mr_i,
    input  reg_e              rd_a_mr_i,
    input  logic              kill_mr_i,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [NBYTES-1:0] dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_resp_valid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              stall_mr_o,
    output logic              valid_mw_o,
    output logic [XLEN-1:0]   alu_result_mw_o,
    output logic [XLEN-1:0]   read_data_sized_mw_o,
    output logic [XLEN-1:0]   pc_next_4_mw_o,
    output logic [XLEN-1:0]   pc_next_imm_mw_o,
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    output logic              misalign_mw_o,
`endif
    output reg_e              rd_a_mw_o
);

    localparam int OFF_W = $clog2(NBYTES);

    mem_state_e        state;
    mem_state_e        state_next;
    mem_size_e         size;
    logic [7:0]        align_full;
    logic [OFF_W-1:0]  off_raw;
    logic [OFF_W-1:0]  off;
    logic [ADDR_W-1:0] addr_full;
    logic              mem_op;
    logic              access;
    logic              req_valid;
    logic              stall;
    logic              load_done;
    logic [NBYTES-1:0] be;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   load_ext;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    logic              misalign;
`endif

    assign size      = mem_size_e'(data_memory_size_mr_i);
    assign addr_full = ADDR_W'(alu_result_mr_i);
    assign off_raw   = alu_result_mr_i[OFF_W-1:0];
    assign mem_op    = valid_mr_i & (mem_read_mr_i | mem_write_mr_i) & ~kill_mr_i;

    always_comb begin
        case (size)
            MEM_B:   align_full = 8'h00;
            MEM_H:   align_full = 8'h01;
            MEM_W:   align_full = 8'h03;
            default: align_full = 8'h07;
        endcase
    end

    assign off = off_raw & ~align_full[OFF_W-1:0];

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    assign misalign = |(off_raw & align_full[OFF_W-1:0]);
    assign access   = mem_op & ~misalign;
`else
    assign access   = mem_op;
`endif

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .size       (size),
        .sign_ext   (data_memory_sign_mr_i),
        .off        (off),
        .store_data (rs2_d_mr_i),
        .load_data  (dmem_rdata_i),
        .be         (be),
        .wdata      (wdata),
        .load_ext   (load_ext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= MS_IDLE;
        else       state <= state_next;
    end

    // A request is only offered from IDLE; a kill during WAIT must still swallow the response.
    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        case (state)
            MS_IDLE: begin
                req_valid = access;
                if (access && dmem_req_ready_i) state_next = MS_WAIT;
            end
            MS_WAIT: begin
                if (dmem_resp_valid_i)  state_next = MS_IDLE;
                else if (kill_mr_i)     state_next = MS_DRAIN;
            end
            MS_DRAIN: begin
                if (dmem_resp_valid_i)  state_next = MS_IDLE;
            end
            default: state_next = MS_IDLE;
        endcase
    end

    assign stall     = (access & ~((state == MS_WAIT) & dmem_resp_valid_i)) | (state == MS_DRAIN);
    assign load_done = access & mem_read_mr_i & (state == MS_WAIT) & dmem_resp_valid_i;

    assign dmem_req_valid_o = req_valid & ~rst_i;
    assign dmem_we_o        = mem_write_mr_i & ~rst_i;
    assign dmem_addr_o      = rst_i ? '0 : {addr_full[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign dmem_be_o        = rst_i ? '0 : be;
    assign dmem_wdata_o     = rst_i ? '0 : wdata;
    assign stall_mr_o       = stall & ~rst_i;

    // Bubbles clear only valid/rd so downstream forwarding never sees a stale destination.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_mw_o           <= 1'b0;
            alu_result_mw_o      <= '0;
            read_data_sized_mw_o <= '0;
            pc_next_4_mw_o       <= '0;
            pc_next_imm_mw_o     <= '0;
            rd_a_mw_o            <= REG_ZERO;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
            misalign_mw_o        <= 1'b0;
`endif
        end else if (stall || kill_mr_i) begin
            valid_mw_o           <= 1'b0;
            rd_a_mw_o            <= REG_ZERO;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
            misalign_mw_o        <= 1'b0;
        end else if (mem_op && misalign) begin
            valid_mw_o           <= 1'b0;
            rd_a_mw_o            <= REG_ZERO;
            misalign_mw_o        <= 1'b1;
`endif
        end else begin
            valid_mw_o           <= valid_mr_i;
            alu_result_mw_o      <= alu_result_mr_i;
            read_data_sized_mw_o <= load_done ? load_ext : '0;
            pc_next_4_mw_o       <= pc_next_4_mr_i;
            pc_next_imm_mw_o     <= pc_next_imm_mr_i;
            rd_a_mw_o            <= rd_a_mr_i;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
            misalign_mw_o        <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_memory_stage_hs.sv
// Directed self-checking bench for memory_stage_hs (32-bit datapath).
module tb_memory_stage_hs;
    import definitions_pkg::*;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int NBYTES = XLEN / 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              valid_mr_i;
    logic              mem_read_mr_i;
    logic              mem_write_mr_i;
    logic              data_memory_sign_mr_i;
    logic [1:0]        data_memory_size_mr_i;
    logic [XLEN-1:0]   rs2_d_mr_i;
    logic [XLEN-1:0]   alu_result_mr_i;
    logic [XLEN-1:0]   pc_next_4_mr_i;
    logic [XLEN-1:0]   pc_next_imm_mr_i;
    reg_e              rd_a_mr_i;
    logic              kill_mr_i;
    logic              dmem_req_valid_o;
    logic              dmem_req_ready_i;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [NBYTES-1:0] dmem_be_o;
    logic [XLEN-1:0]   dmem_wdata_o;
    logic              dmem_resp_valid_i;
    logic [XLEN-1:0]   dmem_rdata_i;
    logic              stall_mr_o;
    logic              valid_mw_o;
    logic [XLEN-1:0]   alu_result_mw_o;
    logic [XLEN-1:0]   read_data_sized_mw_o;
    logic [XLEN-1:0]   pc_next_4_mw_o;
    logic [XLEN-1:0]   pc_next_imm_mw_o;
    reg_e              rd_a_mw_o;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    logic              misalign_mw_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int stall_cnt;
    int wr_cnt;

    always #5 clk_i = ~clk_i;

    memory_stage_hs #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .valid_mr_i            (valid_mr_i),
        .mem_read_mr_i         (mem_read_mr_i),
        .mem_write_mr_i        (mem_write_mr_i),
        .data_memory_sign_mr_i (data_memory_sign_mr_i),
        .data_memory_size_mr_i (data_memory_size_mr_i),
        .rs2_d_mr_i            (rs2_d_mr_i),
        .alu_result_mr_i       (alu_result_mr_i),
        .pc_next_4_mr_i        (pc_next_4_mr_i),
        .pc_next_imm_mr_i      (pc_next_imm_mr_i),
        .rd_a_mr_i             (rd_a_mr_i),
        .kill_mr_i             (kill_mr_i),
        .dmem_req_valid_o      (dmem_req_valid_o),
        .dmem_req_ready_i      (dmem_req_ready_i),
        .dmem_we_o             (dmem_we_o),
        .dmem_addr_o           (dmem_addr_o),
        .dmem_be_o             (dmem_be_o),
        .dmem_wdata_o          (dmem_wdata_o),
        .dmem_resp_valid_i     (dmem_resp_valid_i),
        .dmem_rdata_i          (dmem_rdata_i),
        .stall_mr_o            (stall_mr_o),
        .valid_mw_o            (valid_mw_o),
        .alu_result_mw_o       (alu_result_mw_o),
        .read_data_sized_mw_o  (read_data_sized_mw_o),
        .pc_next_4_mw_o        (pc_next_4_mw_o),
        .pc_next_imm_mw_o      (pc_next_imm_mw_o),
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
        .misalign_mw_o         (misalign_mw_o),
`endif
        .rd_a_mw_o             (rd_a_mw_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        valid_mr_i        = 1'b0;
        mem_read_mr_i     = 1'b0;
        mem_write_mr_i    = 1'b0;
        kill_mr_i         = 1'b0;
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b0;
    endtask

    task automatic applyStimulus(input logic rd_op, input logic wr_op, input logic sgn,
                                 input mem_size_e sz, input logic [31:0] store_val,
                                 input logic [31:0] addr, input reg_e rd);
        valid_mr_i            = 1'b1;
        mem_read_mr_i         = rd_op;
        mem_write_mr_i        = wr_op;
        data_memory_sign_mr_i = sgn;
        data_memory_size_mr_i = sz;
        rs2_d_mr_i            = store_val;
        alu_result_mr_i       = addr;
        rd_a_mr_i             = rd;
        kill_mr_i             = 1'b0;
    endtask

    initial begin
        rst_i                 = 1'b1;
        idleInputs();
        data_memory_sign_mr_i = 1'b0;
        data_memory_size_mr_i = MEM_W;
        rs2_d_mr_i            = '0;
        alu_result_mr_i       = '0;
        pc_next_4_mr_i        = 32'h0000_1004;
        pc_next_imm_mr_i      = 32'h0000_2000;
        rd_a_mr_i             = REG_ZERO;
        dmem_rdata_i          = '0;

        // Reset state
        #2;
        checkOutput("rst_valid_mw", valid_mw_o, 0);
        checkOutput("rst_rd_mw", rd_a_mw_o, REG_ZERO);
        checkOutput("rst_alu_mw", alu_result_mw_o, 0);
        checkOutput("rst_req_valid", dmem_req_valid_o, 0);
        tick();
        tick();
        rst_i = 1'b0;

        // SW 0xDEADBEEF @0x104, accepted at once, response next cycle
        applyStimulus(1'b0, 1'b1, 1'b0, MEM_W, 32'hDEAD_BEEF, 32'h104, REG_ZERO);
        dmem_req_ready_i = 1'b1;
        #1;
        checkOutput("sw_req_valid", dmem_req_valid_o, 1);
        checkOutput("sw_we", dmem_we_o, 1);
        checkOutput("sw_addr", dmem_addr_o, 32'h104);
        checkOutput("sw_be", dmem_be_o, 4'hF);
        checkOutput("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
        checkOutput("sw_stall_accept", stall_mr_o, 1);
        tick();
        checkOutput("sw_bubble_valid", valid_mw_o, 0);
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b1;
        #1;
        checkOutput("sw_stall_resp", stall_mr_o, 0);
        checkOutput("sw_no_new_req", dmem_req_valid_o, 0);
        tick();
        checkOutput("sw_valid_mw", valid_mw_o, 1);
        checkOutput("sw_rd_mw", rd_a_mw_o, REG_ZERO);
        checkOutput("sw_alu_mw", alu_result_mw_o, 32'h104);
        checkOutput("sw_rdata_mw", read_data_sized_mw_o, 0);
        checkOutput("sw_pc4_mw", pc_next_4_mw_o, 32'h0000_1004);
        idleInputs();

        // Store lane steering without acceptance
        applyStimulus(1'b0, 1'b1, 1'b0, MEM_H, 32'h1234_ABCD, 32'h102, REG_ZERO);
        #1;
        checkOutput("sh_be", dmem_be_o, 4'hC);
        checkOutput("sh_wdata", dmem_wdata_o, 32'hABCD_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, MEM_B, 32'h0000_00EF, 32'h101, REG_ZERO);
        #1;
        checkOutput("sb_be", dmem_be_o, 4'h2);
        checkOutput("sb_wdata", dmem_wdata_o, 32'hEFEF_EF00);
        idleInputs();
        tick();

        // LB signed then LBU @0x103
        for (int s = 1; s >= 0; s--) begin
            applyStimulus(1'b1, 1'b0, s[0], MEM_B, 32'h0, 32'h103, REG_A0);
            dmem_req_ready_i = 1'b1;
            #1;
            checkOutput("lb_be", dmem_be_o, 4'h8);
            checkOutput("lb_addr", dmem_addr_o, 32'h100);
            tick();
            dmem_req_ready_i  = 1'b0;
            dmem_resp_valid_i = 1'b1;
            dmem_rdata_i      = 32'h8012_3456;
            tick();
            checkOutput("lb_valid_mw", valid_mw_o, 1);
            checkOutput("lb_rd_mw", rd_a_mw_o, REG_A0);
            checkOutput("lb_data_mw", read_data_sized_mw_o, (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080);
            idleInputs();
        end

        // LH @0x102: ready low three cycles, response two cycles after acceptance
        applyStimulus(1'b1, 1'b0, 1'b1, MEM_H, 32'h0, 32'h102, REG_A3);
        dmem_rdata_i = 32'h8001_1234;
        stall_cnt    = 0;
        wr_cnt       = 0;
        for (int c = 0; c < 6; c++) begin
            dmem_req_ready_i  = (c == 3);
            dmem_resp_valid_i = (c == 5);
            #1;
            if (stall_mr_o) stall_cnt++;
            if (c < 4) begin
                checkOutput("lh_req_held", dmem_req_valid_o, 1);
                checkOutput("lh_addr_held", dmem_addr_o, 32'h100);
                checkOutput("lh_be_held", dmem_be_o, 4'hC);
            end
            tick();
            if (valid_mw_o) wr_cnt++;
        end
        checkOutput("lh_data_mw", read_data_sized_mw_o, 32'hFFFF_8001);
        checkOutput("lh_rd_mw", rd_a_mw_o, REG_A3);
        idleInputs();
        #1;
        tick();
        if (valid_mw_o) wr_cnt++;
        checkOutput("lh_stall_cycles", stall_cnt, 5);
        checkOutput("lh_write_once", wr_cnt, 1);

        // Kill during WAIT: drain the late response, then a waiting ADD passes
        applyStimulus(1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h200, REG_A1);
        dmem_req_ready_i = 1'b1;
        tick();
        dmem_req_ready_i = 1'b0;
        kill_mr_i        = 1'b1;
        #1;
        checkOutput("kill_stall", stall_mr_o, 0);
        tick();
        checkOutput("kill_bubble", valid_mw_o, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, MEM_W, 32'h0, 32'h77, REG_A2);
        #1;
        checkOutput("drain_stall", stall_mr_o, 1);
        checkOutput("drain_no_req", dmem_req_valid_o, 0);
        tick();
        dmem_resp_valid_i = 1'b1;
        dmem_rdata_i      = 32'h1111_2222;
        #1;
        checkOutput("drain_resp_stall", stall_mr_o, 1);
        tick();
        checkOutput("drain_discard_valid", valid_mw_o, 0);
        checkOutput("drain_discard_rd", rd_a_mw_o, REG_ZERO);
        dmem_resp_valid_i = 1'b0;
        #1;
        checkOutput("drain_done_stall", stall_mr_o, 0);
        tick();
        checkOutput("add_after_drain_valid", valid_mw_o, 1);
        checkOutput("add_after_drain_rd", rd_a_mw_o, REG_A2);
        checkOutput("add_after_drain_data", read_data_sized_mw_o, 0);
        idleInputs();

        // ADD back-to-back with a load
        applyStimulus(1'b0, 1'b0, 1'b0, MEM_W, 32'h0, 32'h55, REG_T0);
        #1;
        checkOutput("add_stall", stall_mr_o, 0);
        checkOutput("add_no_req", dmem_req_valid_o, 0);
        tick();
        checkOutput("add_valid_mw", valid_mw_o, 1);
        checkOutput("add_rd_mw", rd_a_mw_o, REG_T0);
        checkOutput("add_alu_mw", alu_result_mw_o, 32'h55);
        applyStimulus(1'b1, 1'b0, 1'b1, MEM_W, 32'h0, 32'h300, REG_T1);
        dmem_req_ready_i = 1'b1;
        #1;
        checkOutput("lw_stall", stall_mr_o, 1);
        tick();
        checkOutput("lw_bubble", valid_mw_o, 0);
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b1;
        dmem_rdata_i      = 32'h9357_9BDF;
        tick();
        checkOutput("lw_valid_mw", valid_mw_o, 1);
        checkOutput("lw_rd_mw", rd_a_mw_o, REG_T1);
        checkOutput("lw_data_mw", read_data_sized_mw_o, 32'h9357_9BDF);
        idleInputs();

        // Misaligned word load
        applyStimulus(1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h102, REG_A4);
        #1;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
        checkOutput("mis_no_req", dmem_req_valid_o, 0);
        checkOutput("mis_no_stall", stall_mr_o, 0);
        tick();
        checkOutput("mis_flag", misalign_mw_o, 1);
        checkOutput("mis_rd", rd_a_mw_o, REG_ZERO);
        checkOutput("mis_valid", valid_mw_o, 0);
`else
        checkOutput("mis_req", dmem_req_valid_o, 1);
        checkOutput("mis_addr", dmem_addr_o, 32'h100);
        checkOutput("mis_be", dmem_be_o, 4'hF);
        tick();
`endif
        idleInputs();
        tick();

        // Reset while WAIT
        applyStimulus(1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h400, REG_S2);
        dmem_req_ready_i = 1'b1;
        tick();
        dmem_req_ready_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        checkOutput("rst_wait_req", dmem_req_valid_o, 0);
        checkOutput("rst_wait_stall", stall_mr_o, 0);
        checkOutput("rst_wait_alu", alu_result_mw_o, 0);
        checkOutput("rst_wait_valid", valid_mw_o, 0);
        tick();
        rst_i = 1'b0;
        idleInputs();
        dmem_resp_valid_i = 1'b1;
        #1;
        checkOutput("stale_resp_stall", stall_mr_o, 0);
        tick();
        checkOutput("stale_resp_valid", valid_mw_o, 0);
        dmem_resp_valid_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h404, REG_S3);
        dmem_req_ready_i = 1'b1;
        #1;
        checkOutput("post_rst_req", dmem_req_valid_o, 1);
        checkOutput("post_rst_addr", dmem_addr_o, 32'h404);
        tick();
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b1;
        dmem_rdata_i      = 32'h0BAD_F00D;
        tick();
        checkOutput("post_rst_rd", rd_a_mw_o, REG_S3);
        checkOutput("post_rst_data", read_data_sized_mw_o, 32'h0BAD_F00D);
        idleInputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
